// File: rtl/burst_pulse_gen.sv
// Burst pulse generator: emits a train of high/low pulses with programmable
// phase lengths and pulse count, or a continuous train until aborted.
// All outputs come straight from flops so downstream logic sees clean edges.
module burst_pulse_gen #(
  parameter int CTR_WIDTH = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 en,
  input  logic                 abort,
  input  logic [CTR_WIDTH-1:0] high_clks,
  input  logic [CTR_WIDTH-1:0] low_clks,
  input  logic [CNT_WIDTH-1:0] num_pulses,
  input  logic                 continuous,
  output logic                 out,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t               state, state_nx;
  logic [CTR_WIDTH-1:0] phase_cnt, phase_nx;
  logic [CNT_WIDTH-1:0] pulse_cnt, pulse_nx;
  logic [CTR_WIDTH-1:0] sh_high, sh_low;
  logic [CNT_WIDTH-1:0] sh_num;
  logic                 sh_cont;
  logic                 load;
  logic                 done_nx;
  logic [CTR_WIDTH-1:0] high_last, low_last;
  logic [CNT_WIDTH:0]   pulse_ext;
  logic                 more;

  // Last phase-counter value of a phase; a programmed length of 0 acts as 1.
  function automatic logic [CTR_WIDTH-1:0] last_count(input logic [CTR_WIDTH-1:0] len);
    return (len == '0) ? '0 : len - CTR_WIDTH'(1);
  endfunction

  // Pulse counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  // Next-state, counter and strobe decisions; abort overrides everything.
  always_comb begin
    state_nx  = state;
    phase_nx  = phase_cnt;
    pulse_nx  = pulse_cnt;
    done_nx   = 1'b0;
    load      = 1'b0;
    high_last = last_count(sh_high);
    low_last  = last_count(sh_low);
    // Widened by one bit so pulse_cnt+1 cannot wrap before the compare.
    pulse_ext = {1'b0, pulse_cnt} + (CNT_WIDTH+1)'(1);
    more      = sh_cont || (pulse_ext < {1'b0, sh_num});

    if (abort) begin
      state_nx = IDLE;
      phase_nx = '0;
      pulse_nx = '0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            load     = 1'b1;
            phase_nx = '0;
            pulse_nx = '0;
            // A zero-length finite burst completes immediately without pulsing.
            if (!continuous && num_pulses == '0) done_nx = 1'b1;
            else                                 state_nx = HIGH;
          end
        end
        HIGH: begin
          if (phase_cnt >= high_last) begin
            state_nx = LOW;
            phase_nx = '0;
          end else begin
            phase_nx = phase_cnt + CTR_WIDTH'(1);
          end
        end
        LOW: begin
          if (phase_cnt >= low_last) begin
            phase_nx = '0;
            pulse_nx = sat_inc(pulse_cnt);
            if (more) begin
              state_nx = HIGH;
            end else begin
              state_nx = IDLE;
              done_nx  = 1'b1;
            end
          end else begin
            phase_nx = phase_cnt + CTR_WIDTH'(1);
          end
        end
        default: begin
          state_nx = IDLE;
          phase_nx = '0;
          pulse_nx = '0;
        end
      endcase
    end
  end

  // State, counters, shadow copies and registered outputs.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= IDLE;
      phase_cnt <= '0;
      pulse_cnt <= '0;
      sh_high   <= '0;
      sh_low    <= '0;
      sh_num    <= '0;
      sh_cont   <= 1'b0;
      out       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      phase_cnt <= phase_nx;
      pulse_cnt <= pulse_nx;
      if (load) begin
        sh_high <= high_clks;
        sh_low  <= low_clks;
        sh_num  <= num_pulses;
        sh_cont <= continuous;
      end
      out  <= (state_nx == HIGH);
      busy <= (state_nx != IDLE);
      done <= done_nx;
    end
  end

endmodule

// File: tb/tb_burst_pulse_gen.sv
// Scoreboard bench for burst_pulse_gen: stimulus pushes per-cycle expected
// {out,busy,done}; a negedge monitor pops and compares one entry per cycle.
module tb_burst_pulse_gen;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       en, abort, continuous;
  logic [7:0] high_clks, low_clks, num_pulses;
  logic       out, busy, done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [2:0] val;
  } exp_t;
  exp_t exp_q[$];

  burst_pulse_gen #(.CTR_WIDTH(8), .CNT_WIDTH(8)) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .en         (en),
    .abort      (abort),
    .high_clks  (high_clks),
    .low_clks   (low_clks),
    .num_pulses (num_pulses),
    .continuous (continuous),
    .out        (out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Monitor: one expected {out,busy,done} per cycle while entries are queued.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({out, busy, done} !== e.val) begin
        errors++;
        $display("FAIL %s: out/busy/done got %b required %b at %0t", e.tag, {out, busy, done}, e.val, $time);
      end
    end
  end

  task automatic push(input string tag, input logic o, input logic b, input logic d, input int n);
    exp_t e;
    e.tag = tag;
    e.val = {o, b, d};
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int budget;
    budget = 2000;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d entries left, required 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    #1;
  endtask

  task automatic check_now(input string tag, input logic [2:0] want);
    checks++;
    if ({out, busy, done} !== want) begin
      errors++;
      $display("FAIL %s: out/busy/done got %b required %b at %0t", tag, {out, busy, done}, want, $time);
    end
  endtask

  task automatic start(input logic [7:0] h, input logic [7:0] l, input logic [7:0] n, input logic c);
    high_clks  = h;
    low_clks   = l;
    num_pulses = n;
    continuous = c;
    en         = 1'b1;
  endtask

  initial begin
    n_reset = 1'b0; en = 1'b0; abort = 1'b0; continuous = 1'b0;
    high_clks = '0; low_clks = '0; num_pulses = '0;
    #12;
    check_now("reset_state", 3'b000);
    @(negedge clk); #1;
    n_reset = 1'b1;
    push("post_reset_idle", 0, 0, 0, 2);
    drain();

    // Basic burst: 2 high, 2 low, 3 pulses, en pulsed one cycle.
    start(8'd2, 8'd2, 8'd3, 1'b0);
    for (int p = 0; p < 3; p++) begin
      push("burst_2_2_3", 1, 1, 0, 2);
      push("burst_2_2_3", 0, 1, 0, 2);
    end
    push("burst_2_2_3_done", 0, 0, 1, 1);
    push("burst_2_2_3_after", 0, 0, 0, 1);
    step(1);
    en = 1'b0;
    drain();

    // High length 0 behaves as 1.
    start(8'd0, 8'd5, 8'd1, 1'b0);
    push("high0", 1, 1, 0, 1);
    push("high0_low", 0, 1, 0, 5);
    push("high0_done", 0, 0, 1, 1);
    push("high0_after", 0, 0, 0, 1);
    step(1);
    en = 1'b0;
    drain();

    // Continuous 1/1 toggle, abort sampled at the end of cycle 40.
    start(8'd1, 8'd1, 8'd0, 1'b1);
    for (int c = 1; c <= 40; c++) push("cont_toggle", c[0], 1, 0, 1);
    push("cont_abort", 0, 0, 0, 3);
    step(1);
    en = 1'b0;
    step(39);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    drain();

    // Zero pulses: no output, done strobe next cycle.
    start(8'd3, 8'd3, 8'd0, 1'b0);
    push("num0_done", 0, 0, 1, 1);
    push("num0_after", 0, 0, 0, 2);
    step(1);
    en = 1'b0;
    drain();

    // en held: two back-to-back bursts; inputs disturbed mid-burst.
    start(8'd3, 8'd1, 8'd2, 1'b0);
    for (int b = 0; b < 2; b++) begin
      push("b2b_high", 1, 1, 0, 3);
      push("b2b_low", 0, 1, 0, 1);
      push("b2b_high", 1, 1, 0, 3);
      push("b2b_low", 0, 1, 0, 1);
      push("b2b_done", 0, 0, 1, 1);
    end
    push("b2b_after", 0, 0, 0, 2);
    step(2);
    high_clks = 8'd1; low_clks = 8'd7; num_pulses = 8'd5; continuous = 1'b1;
    step(4);
    high_clks = 8'd3; low_clks = 8'd1; num_pulses = 8'd2; continuous = 1'b0;
    step(6);
    high_clks = 8'd9; low_clks = 8'd9; num_pulses = 8'd9; continuous = 1'b1;
    en = 1'b0;
    drain();
    continuous = 1'b0;

    // abort and en together in IDLE: nothing starts.
    start(8'd1, 8'd1, 8'd1, 1'b0);
    abort = 1'b1;
    push("abort_prio", 0, 0, 0, 3);
    step(1);
    en = 1'b0; abort = 1'b0;
    drain();

    // abort landing on the final LOW exit suppresses done.
    start(8'd1, 8'd1, 8'd1, 1'b0);
    push("abort_last_high", 1, 1, 0, 1);
    push("abort_last_low", 0, 1, 0, 1);
    push("abort_last_nodone", 0, 0, 0, 3);
    step(1);
    en = 1'b0;
    step(1);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    drain();

    // Maximum high phase length reachable without wrap.
    start(8'd255, 8'd1, 8'd1, 1'b0);
    push("max_high", 1, 1, 0, 255);
    push("max_high_low", 0, 1, 0, 1);
    push("max_high_done", 0, 0, 1, 1);
    push("max_high_after", 0, 0, 0, 1);
    step(1);
    en = 1'b0;
    drain();

    // Maximum pulse count reachable without wrap.
    start(8'd1, 8'd1, 8'd255, 1'b0);
    for (int p = 0; p < 255; p++) begin
      push("max_num", 1, 1, 0, 1);
      push("max_num", 0, 1, 0, 1);
    end
    push("max_num_done", 0, 0, 1, 1);
    push("max_num_after", 0, 0, 0, 1);
    step(1);
    en = 1'b0;
    drain();

    // Asynchronous reset during HIGH.
    start(8'd3, 8'd1, 8'd2, 1'b0);
    push("rst_pre", 1, 1, 0, 2);
    step(1);
    en = 1'b0;
    step(1);
    n_reset = 1'b0;
    #1;
    check_now("rst_async", 3'b000);
    @(negedge clk);
    check_now("rst_held", 3'b000);
    #1;
    n_reset = 1'b1;
    push("rst_after", 0, 0, 0, 6);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the stimulus itself stalls.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1);
  end

endmodule
